// File: rtl/pong_status_tx_pkg.sv
// Shared definitions for the pong status UART transmitter: packet layout,
// controller state encoding and small packet/baud helpers.
package pong_status_tx_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hA5;
  localparam int         PKT_LEN    = 5;
  localparam int         STAT_W     = 10;
  localparam int         FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT
  } ctrl_state_e;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Snapshot layout is {score_p1[3:0], score_p2[3:0], game_over, game_startup}.
  function automatic logic [7:0] pkt_byte(input logic [STAT_W-1:0] snap,
                                          input logic [2:0]        idx);
    logic [7:0] b1, b2, b3;
    b1 = {4'h0, snap[9:6]};
    b2 = {4'h0, snap[5:2]};
    b3 = {6'b0, snap[1:0]};
    case (idx)
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      3'd4:    return b1 ^ b2 ^ b3;
      default: return PKT_HEADER;
    endcase
  endfunction

endpackage

// File: rtl/pong_status_tx_uart_tx_byte.sv
// 8N1 byte serializer. A start presented during the last stop-bit cycle is
// accepted immediately, so consecutive bytes go out with no idle gap.
module uart_tx_byte
  import pong_status_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  last_cycle;
  logic                  ready;

  assign last_cycle = active_q && (bit_idx_q == BIT_LAST) && (baud_cnt_q == BAUD_LAST);
  assign ready      = !active_q || last_cycle;

  always_comb begin
    active_d   = active_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    frame_d    = frame_q;
    if (active_q) begin
      if (baud_cnt_q == BAUD_LAST) begin
        baud_cnt_d = '0;
        frame_d    = {1'b1, frame_q[FRAME_BITS-1:1]};
        if (bit_idx_q == BIT_LAST) begin
          active_d  = 1'b0;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q + CW'(1);
      end
    end
    if (start && ready) begin
      active_d   = 1'b1;
      bit_idx_d  = '0;
      baud_cnt_d = '0;
      frame_d    = {1'b1, data, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q   <= 1'b0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      frame_q    <= '1;
    end else begin
      active_q   <= active_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      frame_q    <= frame_d;
    end
  end

  assign tx   = active_q ? frame_q[0] : 1'b1;
  assign done = last_cycle;
  assign busy = active_q;

endmodule

// File: rtl/pong_status_tx.sv
// Sends a 5-byte status packet over UART whenever the synchronized game status
// settles to a new value, on the first stable value after reset, or on request.
module pong_status_tx
  import pong_status_tx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  input  logic       game_over,
  input  logic       game_startup,
  input  logic       report_req,
  output logic       uart_tx,
  output logic       busy
);

  localparam int         CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam logic [2:0] LAST_IDX     = 3'(PKT_LEN - 1);

  logic [STAT_W-1:0] stat_raw;
  logic [STAT_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]        fill_q, fill_d;
  logic              snap_valid;

  ctrl_state_e       state_q, state_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [STAT_W-1:0] pkt_q, pkt_d;
  logic [STAT_W-1:0] last_sent_q, last_sent_d;
  logic              sent_once_q, sent_once_d;
  logic              report_pend_q, report_pend_d;

  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;

  assign stat_raw = {score_p1, score_p2, game_over, game_startup};

  // fill_q keeps the all-zero reset contents of the synchronizer from being
  // mistaken for a stable snapshot right after reset release.
  always_comb begin
    sync1_d = stat_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
  end

  assign snap_valid = (fill_q == 2'd3) && (sync2_q == prev_q);

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    pkt_d         = pkt_q;
    last_sent_d   = last_sent_q;
    sent_once_d   = sent_once_q;
    report_pend_d = report_pend_q || report_req;
    tx_start      = 1'b0;
    tx_data       = PKT_HEADER;
    case (state_q)
      ST_IDLE: begin
        if (snap_valid && (sync2_q != last_sent_q || !sent_once_q || report_pend_q))
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // prev_q now holds exactly the value judged stable in IDLE.
        pkt_d         = prev_q;
        last_sent_d   = prev_q;
        sent_once_d   = 1'b1;
        report_pend_d = report_req;
        tx_start      = 1'b1;
        tx_data       = PKT_HEADER;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) begin
          if (byte_idx_q != LAST_IDX) begin
            tx_start = 1'b1;
            tx_data  = pkt_byte(pkt_q, byte_idx_q + 3'd1);
          end
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (byte_idx_q == LAST_IDX) begin
          byte_idx_d = '0;
          state_d    = ST_IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
          state_d    = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      fill_q        <= '0;
      state_q       <= ST_IDLE;
      byte_idx_q    <= '0;
      pkt_q         <= '0;
      last_sent_q   <= '0;
      sent_once_q   <= 1'b0;
      report_pend_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      fill_q        <= fill_d;
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      pkt_q         <= pkt_d;
      last_sent_q   <= last_sent_d;
      sent_once_q   <= sent_once_d;
      report_pend_q <= report_pend_d;
    end
  end

  // Serializer busy spans the first start bit through the final stop bit,
  // since the bytes of a packet are chained without a gap.
  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_data),
    .tx   (uart_tx),
    .done (tx_done),
    .busy (busy)
  );

endmodule

// File: tb/tb_pong_status_tx.sv
// Bench for pong_status_tx: a cycle-level line model checks uart_tx and busy
// against queued expected packets; directed scenarios drive the inputs.
module tb_pong_status_tx;

  // 1 MHz / 95 kbaud = 10.53, rounded to nearest gives 11 clocks per bit.
  localparam int CLK_HZ_T = 1_000_000;
  localparam int BAUD_T   = 95_000;
  localparam int CPB      = 11;
  localparam int PKT_CYC  = 50 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] score_p1 = 4'd0;
  logic [3:0] score_p2 = 4'd0;
  logic       game_over = 1'b0;
  logic       game_startup = 1'b1;
  logic       report_req = 1'b0;
  logic       uart_tx;
  logic       busy;

  always #5 clk = ~clk;

  pong_status_tx #(
    .CLK_HZ(CLK_HZ_T),
    .BAUD  (BAUD_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .game_over   (game_over),
    .game_startup(game_startup),
    .report_req  (report_req),
    .uart_tx     (uart_tx),
    .busy        (busy)
  );

  int          total = 0;
  int          bad = 0;
  logic [39:0] exp_q[$];
  logic [39:0] cur_pkt;
  bit          in_pkt = 0;
  bit          bogus = 0;
  int          cur_cyc = 0;
  int          pkts_done = 0;
  int          bitn, bk, bb, expbit;
  logic [7:0]  bv;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Packet bytes, byte 0 in the low 8 bits.
  function automatic logic [39:0] mk_pkt(input int p1, input int p2, input int ov, input int st);
    logic [7:0] b1, b2, b3;
    b1 = 8'(p1);
    b2 = 8'(p2);
    b3 = 8'(ov * 2 + st);
    return {b1 ^ b2 ^ b3, b3, b2, b1, 8'hA5};
  endfunction

  // Line model: every cycle of a packet has a known level given its position.
  always @(negedge clk) begin
    if (!rst) begin
      in_pkt  = 0;
      bogus   = 0;
      cur_cyc = 0;
      chk("reset_tx", int'(uart_tx), 1);
      chk("reset_busy", int'(busy), 0);
    end else begin
      if (!in_pkt && uart_tx === 1'b0) begin
        in_pkt  = 1;
        cur_cyc = 0;
        if (exp_q.size() == 0) begin
          bogus = 1;
          chk("unexpected_packet", 1, 0);
        end else begin
          bogus   = 0;
          cur_pkt = exp_q.pop_front();
        end
      end
      if (!in_pkt) begin
        chk("idle_busy", int'(busy), 0);
      end else begin
        if (!bogus) begin
          bitn = cur_cyc / CPB;
          bb   = bitn / 10;
          bk   = bitn % 10;
          bv   = cur_pkt[8*bb +: 8];
          expbit = (bk == 0) ? 0 : (bk == 9) ? 1 : int'(bv[bk-1]);
          chk($sformatf("tx_byte%0d_bit%0d_cyc%0d", bb, bk, cur_cyc), int'(uart_tx), expbit);
        end
        chk("pkt_busy", int'(busy), 1);
        cur_cyc++;
        if (cur_cyc == PKT_CYC) begin
          in_pkt = 0;
          if (!bogus) pkts_done++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pkts(input int n, input string name);
    int cnt;
    cnt = 0;
    while (pkts_done < n && cnt < 4 * PKT_CYC) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, (pkts_done >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_busy(input string name);
    int cnt;
    cnt = 0;
    while (busy !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, int'(busy), 1);
  endtask

  task automatic pulse_report();
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
  endtask

  int lat;
  int cnt;

  initial begin
    // Reset release: first stable snapshot is always sent.
    cycles(3);
    chk("init_tx", int'(uart_tx), 1);
    chk("init_busy", int'(busy), 0);
    exp_q.push_back(40'h01_01_00_00_A5);
    rst = 1'b1;
    wait_pkts(1, "startup_packet_done");
    cycles(60);
    chk("startup_pkt_count", pkts_done, 1);
    chk("startup_queue_empty", exp_q.size(), 0);

    // New stable status, with latency from input change to start bit.
    exp_q.push_back(40'h04_02_05_03_A5);
    score_p1 = 4'd3; score_p2 = 4'd5; game_over = 1'b1; game_startup = 1'b0;
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat > 7) begin
      bad++;
      $display("FAIL start_latency: got %0d cycles, expected at most 7", lat);
    end
    wait_pkts(2, "status_packet_done");
    cycles(60);
    chk("status_pkt_count", pkts_done, 2);

    // Changes while busy collapse to one packet with the final value.
    exp_q.push_back(mk_pkt(1, 5, 1, 0));
    score_p1 = 4'd1;
    wait_busy("collapse_busy_seen");
    score_p1 = 4'd2;
    cycles(30);
    score_p1 = 4'd3;
    cycles(30);
    exp_q.push_back(mk_pkt(3, 5, 1, 0));
    wait_pkts(4, "collapse_packets_done");
    cycles(100);
    chk("collapse_pkt_count", pkts_done, 4);
    chk("collapse_queue_empty", exp_q.size(), 0);

    // Report requests: one in idle, three during that packet -> one repeat.
    exp_q.push_back(mk_pkt(3, 5, 1, 0));
    pulse_report();
    wait_busy("report_busy_seen");
    for (int i = 0; i < 3; i++) begin
      cycles(20);
      pulse_report();
    end
    exp_q.push_back(mk_pkt(3, 5, 1, 0));
    wait_pkts(6, "report_packets_done");
    cycles(100);
    chk("report_pkt_count", pkts_done, 6);
    chk("report_queue_empty", exp_q.size(), 0);

    // One-cycle glitch on an input must not produce a packet.
    game_over = 1'b0;
    @(negedge clk);
    game_over = 1'b1;
    cycles(100);
    chk("glitch_pkt_count", pkts_done, 6);
    chk("glitch_busy", int'(busy), 0);

    // Reset during byte 2 aborts at once; a full packet follows release.
    exp_q.push_back(mk_pkt(3, 9, 1, 0));
    score_p2 = 4'd9;
    wait_busy("abort_busy_seen");
    cnt = 0;
    while (!(in_pkt && cur_cyc >= 25 * CPB) && cnt < 2 * PKT_CYC) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_reached_byte2", (in_pkt && cur_cyc >= 25 * CPB) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_tx_immediate", int'(uart_tx), 1);
    chk("abort_busy_immediate", int'(busy), 0);
    @(negedge clk);
    cycles(5);
    exp_q.push_back(mk_pkt(3, 9, 1, 0));
    rst = 1'b1;
    wait_pkts(7, "after_abort_packet_done");
    cycles(60);
    chk("after_abort_pkt_count", pkts_done, 7);
    chk("after_abort_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
